// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU defaults and byte-enable merge helper
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;
    localparam int ZERO_IDX   = 0;

    // One byte lane of a byte-enabled write: enabled lanes take the new byte.
    function automatic logic [7:0] be_byte(input logic [7:0] old_b,
                                           input logic [7:0] new_b,
                                           input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - register file read/write/reserve/debug bus
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W/8-1:0]   wr_be;
    logic [DATA_W-1:0]     wr_data;
    logic                  rsv_valid;
    logic [ADDR_W-1:0]     rsv_addr;
    logic                  rsv_ready;
    logic [ADDR_W-1:0]     dbg_sel;
    logic [DATA_W-1:0]     dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_be, wr_data, rsv_valid, rsv_addr, dbg_sel,
        input  rd_data, rd_busy, rsv_ready, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_be, wr_data, rsv_valid, rsv_addr, dbg_sel,
        output rd_data, rd_busy, rsv_ready, dbg_data
    );
endinterface

// File: rtl/regfile_sb_rdport.sv
// rtl/regfile_sb_rdport.sv - one combinational read port with zero-reg masking
// Optional write-to-read forwarding under REGFILE_SB_BYPASS_EN.
module regfile_sb_rdport
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [DATA_W-1:0]    i_rf [2**ADDR_W],
    input  logic [2**ADDR_W-1:0] i_busy,
    input  logic                 i_wr_en,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [DATA_W/8-1:0]  i_wr_be,
    input  logic [DATA_W-1:0]    i_wr_data,
    output logic [DATA_W-1:0]    o_data,
    output logic                 o_busy
);
    localparam bit ZR = (ZERO_REG != 0);

    logic              w_zero;
    logic              w_hit;
    logic [DATA_W-1:0] w_stored;
    logic [DATA_W-1:0] w_fwd;

    assign w_zero   = ZR && (i_addr == ADDR_W'(ZERO_IDX));
    assign w_stored = i_rf[i_addr];

`ifdef REGFILE_SB_BYPASS_EN
    logic [DATA_W-1:0] w_merged;

    always_comb begin
        w_merged = w_stored;
        for (int b = 0; b < DATA_W/8; b++) begin
            w_merged[b*8 +: 8] = be_byte(w_stored[b*8 +: 8], i_wr_data[b*8 +: 8], i_wr_be[b]);
        end
    end

    assign w_hit = i_wr_en && (i_wr_addr == i_addr) && !w_zero;
    assign w_fwd = w_hit ? w_merged : w_stored;
`else
    logic w_unused;
    assign w_unused = &{1'b0, i_wr_en, i_wr_addr, i_wr_be, i_wr_data};
    assign w_hit    = 1'b0;
    assign w_fwd    = w_stored;
`endif

    // A forwarded write-back means the operand is ready now, so busy is hidden.
    assign o_data = w_zero ? '0 : w_fwd;
    assign o_busy = !w_zero && !w_hit && i_busy[i_addr];

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with per-register busy scoreboard
// Read ports honour REGFILE_SB_BYPASS_EN through regfile_sb_rdport.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_rf [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic              w_wr_zero;
    logic              w_rsv_zero;
    logic              w_rsv_ready;
    logic [DATA_W-1:0] w_wr_word;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [DATA_W-1:0] w_rd_data [NRD];
    logic              w_rd_busy [NRD];

    assign w_wr_zero   = ZR && (bus.wr_addr == ADDR_W'(ZERO_IDX));
    assign w_rsv_zero  = ZR && (bus.rsv_addr == ADDR_W'(ZERO_IDX));
    assign w_rsv_ready = w_rsv_zero || !r_busy[bus.rsv_addr];
    assign bus.rsv_ready = w_rsv_ready;
    assign bus.dbg_data  = (ZR && (bus.dbg_sel == ADDR_W'(ZERO_IDX))) ? '0 : r_rf[bus.dbg_sel];

    always_comb begin
        w_wr_word = r_rf[bus.wr_addr];
        for (int b = 0; b < DATA_W/8; b++) begin
            w_wr_word[b*8 +: 8] = be_byte(r_rf[bus.wr_addr][b*8 +: 8], bus.wr_data[b*8 +: 8], bus.wr_be[b]);
        end
    end

    // Write-back clears first so a same-edge accepted reservation wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.wr_en) begin
            w_busy_nxt[bus.wr_addr] = 1'b0;
        end
        if (bus.rsv_valid && w_rsv_ready && !w_rsv_zero) begin
            w_busy_nxt[bus.rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (bus.wr_en && !w_wr_zero) begin
                r_rf[bus.wr_addr] <= w_wr_word;
            end
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_sb_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .i_addr    (bus.rd_addr[k*ADDR_W +: ADDR_W]),
            .i_rf      (r_rf),
            .i_busy    (r_busy),
            .i_wr_en   (bus.wr_en),
            .i_wr_addr (bus.wr_addr),
            .i_wr_be   (bus.wr_be),
            .i_wr_data (bus.wr_data),
            .o_data    (w_rd_data[k]),
            .o_busy    (w_rd_busy[k])
        );
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            bus.rd_data[k*DATA_W +: DATA_W] = w_rd_data[k];
            bus.rd_busy[k]                  = w_rd_busy[k];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - bench for regfile_sb, expectations follow REGFILE_SB_BYPASS_EN
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

`ifdef REGFILE_SB_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'hDEADBEEF;
`else
    localparam logic [31:0] BYP_EXP = 32'h0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    bit   chk_on;

    logic [31:0] m_rf   [32];
    bit          m_busy [32];

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();

    regfile_sb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] merged(input logic [4:0] a);
        return (m_rf[a] & ~be_mask(bus.wr_be)) | (bus.wr_data & be_mask(bus.wr_be));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_SB_BYPASS_EN
        if (bus.wr_en && bus.wr_addr == a) return merged(a);
`endif
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        if (bus.wr_en && bus.wr_addr == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic exp_ready();
        return (bus.rsv_addr == 5'd0) || !m_busy[bus.rsv_addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_commit();
        bit acc;
        if (!rst) return;
        acc = bus.rsv_valid && exp_ready();
        if (bus.wr_en) begin
            if (bus.wr_addr != 5'd0) m_rf[bus.wr_addr] = merged(bus.wr_addr);
            m_busy[bus.wr_addr] = 1'b0;
        end
        if (acc && bus.rsv_addr != 5'd0) m_busy[bus.rsv_addr] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("rd_data[%0d]", k), bus.rd_data[k*DW +: DW], exp_rd(bus.rd_addr[k*AW +: AW]));
                chk($sformatf("rd_busy[%0d]", k), {31'b0, bus.rd_busy[k]}, {31'b0, exp_busy(bus.rd_addr[k*AW +: AW])});
            end
            chk("rsv_ready", {31'b0, bus.rsv_ready}, {31'b0, exp_ready()});
            chk("dbg_data", bus.dbg_data, (bus.dbg_sel == 5'd0) ? 32'h0 : m_rf[bus.dbg_sel]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drv_idle();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_be     = '0;
        bus.wr_data   = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
    endtask

    task automatic drv_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_be   = be;
    endtask

    task automatic drv_rsv(input logic [4:0] a);
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = a;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        bus.rd_addr[k*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rd(input int k);
        return bus.rd_data[k*DW +: DW];
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_on  = 1'b1;
        model_reset();
        rst         = 1'b0;
        bus.rd_addr = '0;
        bus.dbg_sel = '0;
        drv_idle();
        #12 rst = 1'b1;

        // Reset state
        set_rd(0, 5'd5);
        #1;
        chk("reset rd_data", rd(0), 32'h0);
        chk("reset rsv_ready", {31'b0, bus.rsv_ready}, 32'h1);

        // Write r5, reserve r6, then async reset mid-cycle
        drv_wr(5'd5, 32'h12345678, 4'hF);
        drv_rsv(5'd6);
        cyc();
        drv_idle();
        bus.rsv_addr = 5'd6;
        set_rd(0, 5'd5);
        set_rd(1, 5'd6);
        #1;
        chk("r5 before reset", rd(0), 32'h12345678);
        chk("r6 busy before reset", {31'b0, bus.rd_busy[1]}, 32'h1);
        chk("r6 rsv_ready before reset", {31'b0, bus.rsv_ready}, 32'h0);
        rst = 1'b0;
        #1;
        model_reset();
        chk("r5 async reset", rd(0), 32'h0);
        chk("rd_busy async reset", {30'b0, bus.rd_busy}, 32'h0);
        chk("rsv_ready async reset", {31'b0, bus.rsv_ready}, 32'h1);
        rst = 1'b1;

        // Byte enables
        drv_wr(5'd3, 32'hAABBCCDD, 4'hF);
        cyc();
        drv_wr(5'd3, 32'h11223344, 4'b0101);
        cyc();
        drv_idle();
        set_rd(0, 5'd3);
        #1;
        chk("byte enable merge", rd(0), 32'hAA22CC44);

        // Zero register
        drv_wr(5'd0, 32'hFFFFFFFF, 4'hF);
        drv_rsv(5'd0);
        set_rd(0, 5'd0);
        #1;
        chk("r0 rsv_ready", {31'b0, bus.rsv_ready}, 32'h1);
        cyc();
        chk("r0 data", rd(0), 32'h0);
        chk("r0 busy", {31'b0, bus.rd_busy[0]}, 32'h0);
        chk("r0 rsv_ready after", {31'b0, bus.rsv_ready}, 32'h1);

        // Scoreboard reserve / write-back
        drv_idle();
        drv_rsv(5'd7);
        cyc();
        set_rd(0, 5'd7);
        #1;
        chk("r7 busy", {31'b0, bus.rd_busy[0]}, 32'h1);
        chk("r7 second rsv_ready", {31'b0, bus.rsv_ready}, 32'h0);
        cyc();
        drv_idle();
        drv_wr(5'd7, 32'h55, 4'hF);
        cyc();
        drv_idle();
        #1;
        chk("r7 busy cleared", {31'b0, bus.rd_busy[0]}, 32'h0);
        chk("r7 data", rd(0), 32'h55);

        // Collision on busy r9: reservation rejected, retry accepted next cycle
        drv_rsv(5'd9);
        cyc();
        drv_wr(5'd9, 32'h99, 4'hF);
        set_rd(0, 5'd9);
        #1;
        chk("busy r9 collision rsv_ready", {31'b0, bus.rsv_ready}, 32'h0);
        cyc();
        bus.wr_en = 1'b0;
        #1;
        chk("r9 not busy after collision", {31'b0, bus.rd_busy[0]}, 32'h0);
        chk("r9 retry rsv_ready", {31'b0, bus.rsv_ready}, 32'h1);
        cyc();
        drv_idle();
        #1;
        chk("r9 busy after retry", {31'b0, bus.rd_busy[0]}, 32'h1);
        chk("r9 data", rd(0), 32'h99);

        // Collision on non-busy r9: reservation wins
        drv_wr(5'd9, 32'h77, 4'hF);
        cyc();
        drv_wr(5'd9, 32'h88, 4'hF);
        drv_rsv(5'd9);
        #1;
        chk("free r9 collision rsv_ready", {31'b0, bus.rsv_ready}, 32'h1);
        cyc();
        drv_idle();
        #1;
        chk("r9 busy after free collision", {31'b0, bus.rd_busy[0]}, 32'h1);
        chk("r9 data after free collision", rd(0), 32'h88);

        // Different addresses, both take effect
        drv_wr(5'd12, 32'h00001234, 4'hF);
        drv_rsv(5'd13);
        cyc();
        drv_idle();
        set_rd(0, 5'd12);
        set_rd(1, 5'd13);
        #1;
        chk("r12 data", rd(0), 32'h00001234);
        chk("r13 busy", {31'b0, bus.rd_busy[1]}, 32'h1);

        // wr_be = 0 still counts as write-back
        drv_wr(5'd13, 32'hFFFFFFFF, 4'h0);
        cyc();
        drv_idle();
        #1;
        chk("r13 busy cleared by be=0", {31'b0, bus.rd_busy[1]}, 32'h0);
        chk("r13 data held", rd(1), 32'h0);

        // Same-cycle read of written register
        set_rd(1, 5'd4);
        bus.dbg_sel = 5'd4;
        drv_wr(5'd4, 32'hDEADBEEF, 4'hF);
        #1;
        chk("r4 same-cycle read", rd(1), BYP_EXP);
        chk("r4 dbg not bypassed", bus.dbg_data, 32'h0);
        cyc();
        drv_idle();
        #1;
        chk("r4 after edge", rd(1), 32'hDEADBEEF);
        chk("r4 dbg after edge", bus.dbg_data, 32'hDEADBEEF);

        // Directed sweep, checked cycle by cycle against the model
        for (int i = 0; i < 24; i++) begin
            drv_wr(5'((i % 8) + 16), 32'h11111111 * i, 4'(i));
            bus.wr_en     = (i % 3) != 2;
            bus.rsv_valid = i[0];
            bus.rsv_addr  = 5'((i * 3) % 32);
            set_rd(0, 5'((i % 8) + 16));
            set_rd(1, 5'((i * 3) % 32));
            bus.dbg_sel   = 5'(i + 8);
            cyc();
        end
        drv_idle();
        cyc();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
